// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM for the MIPS-subset CPU: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath controls and counts retired instructions.
module multicycle_controller #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        instruction,
    input  logic               zero,
    input  logic               mem_ready,
    output logic [2:0]         state,
    output logic               MemRd,
    output logic               MemWr,
    output logic               IRWr,
    output logic               PCWr,
    output logic [1:0]         PCsrc,
    output logic               RegWr,
    output logic [1:0]         RegDst,
    output logic [1:0]         ALUsrc,
    output logic [2:0]         ALUcntrl,
    output logic               ExtendMethod,
    output logic               MemToReg,
    output logic               illegal,
    output logic [COUNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;
    localparam logic [1:0] DST_RT    = 2'd0;
    localparam logic [1:0] DST_RD    = 2'd1;
    localparam logic [1:0] DST_RA    = 2'd2;
    localparam logic [1:0] SRC_IMM   = 2'd0;
    localparam logic [1:0] SRC_PC    = 2'd1;
    localparam logic [1:0] SRC_DB    = 2'd2;
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_SLT   = 3'd3;

    state_t             state_q, state_d;
    logic               illegal_q, illegal_d;
    logic [COUNT_W-1:0] retired_q, retired_d;

    logic [5:0] op_s, funct_s;
    logic       is_rtype_s, is_alu_r_s, is_slt_s, is_jr_s, is_jal_s;
    logic       is_addi_s, is_addiu_s, is_beq_s, is_bne_s, is_lw_s, is_sw_s, legal_s;
    logic       unused_s;
    logic       mem_rd_s, mem_wr_s, ir_wr_s, pc_wr_s, reg_wr_s, retire_s;

    assign op_s       = instruction[31:26];
    assign funct_s    = instruction[5:0];
    assign unused_s   = ^instruction[25:6];
    assign is_rtype_s = (op_s == OP_RTYPE);
    assign is_slt_s   = is_rtype_s && (funct_s == FN_SLT);
    assign is_alu_r_s = is_rtype_s && ((funct_s == FN_ADD) || (funct_s == FN_ADDU) || (funct_s == FN_SLT));
    assign is_jr_s    = is_rtype_s && (funct_s == FN_JR);
    assign is_jal_s   = (op_s == OP_JAL);
    assign is_addi_s  = (op_s == OP_ADDI);
    assign is_addiu_s = (op_s == OP_ADDIU);
    assign is_beq_s   = (op_s == OP_BEQ);
    assign is_bne_s   = (op_s == OP_BNE);
    assign is_lw_s    = (op_s == OP_LW);
    assign is_sw_s    = (op_s == OP_SW);
    assign legal_s    = is_alu_r_s || is_jr_s || is_jal_s || is_addi_s || is_addiu_s ||
                        is_beq_s || is_bne_s || is_lw_s || is_sw_s;

    // Next-state and per-state datapath controls
    always_comb begin
        state_d      = state_q;
        mem_rd_s     = 1'b0;
        mem_wr_s     = 1'b0;
        ir_wr_s      = 1'b0;
        pc_wr_s      = 1'b0;
        reg_wr_s     = 1'b0;
        PCsrc        = PC_PLUS4;
        RegDst       = DST_RT;
        ALUsrc       = SRC_IMM;
        ALUcntrl     = ALU_ADD;
        ExtendMethod = 1'b0;
        MemToReg     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_rd_s = 1'b1;
                if (mem_ready) begin
                    ir_wr_s = 1'b1;
                    pc_wr_s = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (!legal_s) begin
                    state_d = S_HALT;
                end else if (is_jal_s) begin
                    reg_wr_s = 1'b1;
                    RegDst   = DST_RA;
                    ALUsrc   = SRC_PC;
                    pc_wr_s  = 1'b1;
                    PCsrc    = PC_JUMP;
                    state_d  = S_FETCH;
                end else if (is_jr_s) begin
                    pc_wr_s = 1'b1;
                    PCsrc   = PC_REG;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_alu_r_s) begin
                    ALUsrc   = SRC_DB;
                    ALUcntrl = is_slt_s ? ALU_SLT : ALU_ADD;
                    state_d  = S_WB;
                end else if (is_addi_s || is_addiu_s) begin
                    ExtendMethod = is_addiu_s;
                    state_d      = S_WB;
                end else if (is_lw_s || is_sw_s) begin
                    state_d = S_MEM;
                end else if (is_beq_s || is_bne_s) begin
                    ALUsrc   = SRC_DB;
                    ALUcntrl = ALU_SUB;
                    // beq takes on zero, bne on non-zero
                    if (zero == is_beq_s) begin
                        pc_wr_s = 1'b1;
                        PCsrc   = PC_BRANCH;
                    end else begin
                        pc_wr_s = 1'b0;
                    end
                    state_d = S_FETCH;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_MEM: begin
                if (is_lw_s) begin
                    mem_rd_s = 1'b1;
                    state_d  = mem_ready ? S_WB : S_MEM;
                end else if (is_sw_s) begin
                    mem_wr_s = 1'b1;
                    state_d  = mem_ready ? S_FETCH : S_MEM;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                reg_wr_s = 1'b1;
                RegDst   = is_alu_r_s ? DST_RD : DST_RT;
                MemToReg = is_lw_s;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    assign retire_s  = ((state_q == S_DECODE) || (state_q == S_EXEC) ||
                        (state_q == S_MEM) || (state_q == S_WB)) && (state_d == S_FETCH);
    assign illegal_d = illegal_q | (state_d == S_HALT);

    // Saturating retired-instruction counter
    always_comb begin
        if (retire_s && (retired_q != {COUNT_W{1'b1}})) begin
            retired_d = retired_q + COUNT_W'(1);
        end else begin
            retired_d = retired_q;
        end
    end

    // State, sticky illegal flag and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Enables drop immediately while reset is held so an in-flight access is abandoned
    assign MemRd   = mem_rd_s & rst_n;
    assign MemWr   = mem_wr_s & rst_n;
    assign IRWr    = ir_wr_s & rst_n;
    assign PCWr    = pc_wr_s & rst_n;
    assign RegWr   = reg_wr_s & rst_n;
    assign state   = state_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected controls go through a
// scoreboard queue; a second instance with COUNT_W=2 checks counter saturation.
module tb_multicycle_controller;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic        zero;
    logic        mem_ready;

    logic [2:0]  state, d2_state;
    logic        MemRd, MemWr, IRWr, PCWr, RegWr, ExtendMethod, MemToReg, illegal;
    logic        d2_MemRd, d2_MemWr, d2_IRWr, d2_PCWr, d2_RegWr, d2_ExtendMethod, d2_MemToReg, d2_illegal;
    logic [1:0]  PCsrc, RegDst, ALUsrc, d2_PCsrc, d2_RegDst, d2_ALUsrc;
    logic [2:0]  ALUcntrl, d2_ALUcntrl;
    logic [15:0] retired;
    logic [1:0]  d2_retired;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    localparam logic [31:0] I_ADDU  = 32'h0022_1821;
    localparam logic [31:0] I_LW    = 32'h8FA8_0004;
    localparam logic [31:0] I_BNE   = 32'h1422_0005;
    localparam logic [31:0] I_JAL   = 32'h0C00_0009;
    localparam logic [31:0] I_JR    = 32'h03E0_0008;
    localparam logic [31:0] I_SW    = 32'hAFA8_0004;
    localparam logic [31:0] I_SLT   = 32'h0022_182A;
    localparam logic [31:0] I_ADDIU = 32'h2442_0001;
    localparam logic [31:0] I_ILL   = 32'hFC00_0000;

    multicycle_controller #(.COUNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
        .state(state), .MemRd(MemRd), .MemWr(MemWr), .IRWr(IRWr), .PCWr(PCWr), .PCsrc(PCsrc),
        .RegWr(RegWr), .RegDst(RegDst), .ALUsrc(ALUsrc), .ALUcntrl(ALUcntrl),
        .ExtendMethod(ExtendMethod), .MemToReg(MemToReg), .illegal(illegal), .retired(retired)
    );

    multicycle_controller #(.COUNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
        .state(d2_state), .MemRd(d2_MemRd), .MemWr(d2_MemWr), .IRWr(d2_IRWr), .PCWr(d2_PCWr),
        .PCsrc(d2_PCsrc), .RegWr(d2_RegWr), .RegDst(d2_RegDst), .ALUsrc(d2_ALUsrc),
        .ALUcntrl(d2_ALUcntrl), .ExtendMethod(d2_ExtendMethod), .MemToReg(d2_MemToReg),
        .illegal(d2_illegal), .retired(d2_retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [19:0] ctl;
        int          ret;
    } exp_t;

    exp_t sb[$];

    // {state, MemRd,MemWr,IRWr,PCWr,RegWr, PCsrc, RegDst, ALUsrc, ALUcntrl, Ext,MemToReg,illegal}
    function automatic logic [19:0] ctl(input logic [2:0] st, input logic [4:0] en,
                                        input logic [1:0] pcs, input logic [1:0] rd,
                                        input logic [1:0] as, input logic [2:0] ac,
                                        input logic [2:0] flg);
        return {st, en, pcs, rd, as, ac, flg};
    endfunction

    function automatic logic [19:0] z(input logic [2:0] st);
        return {st, 17'd0};
    endfunction

    function automatic logic [19:0] fr();
        return ctl(3'd0, 5'b10110, 2'd0, 2'd0, 2'd0, 3'd0, 3'b000);
    endfunction

    function automatic logic [19:0] fw();
        return ctl(3'd0, 5'b10000, 2'd0, 2'd0, 2'd0, 3'd0, 3'b000);
    endfunction

    task automatic step(input string tag, input logic [19:0] exp_ctl, input int exp_ret);
        exp_t        e;
        logic [19:0] obs;
        logic [15:0] r16;
        logic [1:0]  r2;
        sb.push_back('{tag, exp_ctl, exp_ret});
        #1;
        e   = sb.pop_front();
        obs = {state, MemRd, MemWr, IRWr, PCWr, RegWr, PCsrc, RegDst, ALUsrc, ALUcntrl,
               ExtendMethod, MemToReg, illegal};
        r16 = e.ret[15:0];
        r2  = (e.ret > 3) ? 2'd3 : e.ret[1:0];
        chk_cnt++;
        assert (obs === e.ctl) pass_cnt++;
        else $error("FAIL %s ctl observed=%05h expected=%05h", e.tag, obs, e.ctl);
        chk_cnt++;
        assert (retired === r16) pass_cnt++;
        else $error("FAIL %s retired observed=%0d expected=%0d", e.tag, retired, r16);
        chk_cnt++;
        assert (d2_retired === r2) pass_cnt++;
        else $error("FAIL %s retired_w2 observed=%0d expected=%0d", e.tag, d2_retired, r2);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        clk         = 1'b0;
        rst_n       = 1'b0;
        instruction = 32'd0;
        zero        = 1'b0;
        mem_ready   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        step("reset", z(3'd0), 0);

        rst_n = 1'b1;
        instruction = I_ADDU;
        step("addu_fetch", fr(), 0);
        step("addu_dec", z(3'd1), 0);
        step("addu_exec", ctl(3'd2, 5'b00000, 2'd0, 2'd0, 2'd2, 3'd0, 3'b000), 0);
        step("addu_wb", ctl(3'd4, 5'b00001, 2'd0, 2'd1, 2'd0, 3'd0, 3'b000), 0);

        instruction = I_LW;
        mem_ready = 1'b0;
        step("lw_fwait0", fw(), 1);
        step("lw_fwait1", fw(), 1);
        mem_ready = 1'b1;
        step("lw_fetch", fr(), 1);
        step("lw_dec", z(3'd1), 1);
        step("lw_exec", z(3'd2), 1);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_mwait", ctl(3'd3, 5'b10000, 2'd0, 2'd0, 2'd0, 3'd0, 3'b000), 1);
        mem_ready = 1'b1;
        step("lw_mem", ctl(3'd3, 5'b10000, 2'd0, 2'd0, 2'd0, 3'd0, 3'b000), 1);
        step("lw_wb", ctl(3'd4, 5'b00001, 2'd0, 2'd0, 2'd0, 3'd0, 3'b010), 1);

        instruction = I_BNE;
        zero = 1'b0;
        step("bne_t_fetch", fr(), 2);
        step("bne_t_dec", z(3'd1), 2);
        step("bne_t_exec", ctl(3'd2, 5'b00010, 2'd1, 2'd0, 2'd2, 3'd1, 3'b000), 2);
        zero = 1'b1;
        step("bne_n_fetch", fr(), 3);
        step("bne_n_dec", z(3'd1), 3);
        step("bne_n_exec", ctl(3'd2, 5'b00000, 2'd0, 2'd0, 2'd2, 3'd1, 3'b000), 3);
        zero = 1'b0;

        instruction = I_JAL;
        step("jal_fetch", fr(), 4);
        step("jal_dec", ctl(3'd1, 5'b00011, 2'd2, 2'd2, 2'd1, 3'd0, 3'b000), 4);
        instruction = I_JR;
        step("jr_fetch", fr(), 5);
        step("jr_dec", ctl(3'd1, 5'b00010, 2'd3, 2'd0, 2'd0, 3'd0, 3'b000), 5);
        instruction = I_SW;
        step("sw_fetch", fr(), 6);
        step("sw_dec", z(3'd1), 6);
        step("sw_exec", z(3'd2), 6);
        step("sw_mem", ctl(3'd3, 5'b01000, 2'd0, 2'd0, 2'd0, 3'd0, 3'b000), 6);
        instruction = I_SLT;
        step("slt_fetch", fr(), 7);
        step("slt_dec", z(3'd1), 7);
        step("slt_exec", ctl(3'd2, 5'b00000, 2'd0, 2'd0, 2'd2, 3'd3, 3'b000), 7);
        step("slt_wb", ctl(3'd4, 5'b00001, 2'd0, 2'd1, 2'd0, 3'd0, 3'b000), 7);

        instruction = I_ILL;
        step("ill_fetch", fr(), 8);
        step("ill_dec", z(3'd1), 8);
        step("halt0", ctl(3'd5, 5'b00000, 2'd0, 2'd0, 2'd0, 3'd0, 3'b001), 8);
        instruction = I_ADDU;
        mem_ready = 1'b0;
        zero = 1'b1;
        step("halt1", ctl(3'd5, 5'b00000, 2'd0, 2'd0, 2'd0, 3'd0, 3'b001), 8);
        mem_ready = 1'b1;
        step("halt2", ctl(3'd5, 5'b00000, 2'd0, 2'd0, 2'd0, 3'd0, 3'b001), 8);
        rst_n = 1'b0;
        zero = 1'b0;
        step("halt_rst", ctl(3'd5, 5'b00000, 2'd0, 2'd0, 2'd0, 3'd0, 3'b001), 8);
        step("halt_exit", z(3'd0), 0);
        rst_n = 1'b1;

        instruction = I_ADDIU;
        for (int i = 0; i < 5; i++) begin
            step("addiu_fetch", fr(), i);
            step("addiu_dec", z(3'd1), i);
            step("addiu_exec", ctl(3'd2, 5'b00000, 2'd0, 2'd0, 2'd0, 3'd0, 3'b100), i);
            step("addiu_wb", ctl(3'd4, 5'b00001, 2'd0, 2'd0, 2'd0, 3'd0, 3'b000), i);
        end

        instruction = I_SW;
        step("sat_fetch", fr(), 5);
        step("rsw_dec", z(3'd1), 5);
        step("rsw_exec", z(3'd2), 5);
        mem_ready = 1'b0;
        step("rsw_mwait0", ctl(3'd3, 5'b01000, 2'd0, 2'd0, 2'd0, 3'd0, 3'b000), 5);
        step("rsw_mwait1", ctl(3'd3, 5'b01000, 2'd0, 2'd0, 2'd0, 3'd0, 3'b000), 5);
        rst_n = 1'b0;
        step("rsw_rst_mem", z(3'd3), 5);
        step("rsw_rst_fetch", z(3'd0), 0);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        step("post_rst_fetch", fr(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
